// File: rtl/tetris_pkg.sv
// Board geometry, cell codes and palette shared by the renderer and the game logic.
// Also holds the small pipeline/FSM types used inside the renderer.
package tetris_pkg;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int CELLS     = ROWS * COLS;
  localparam int CELL_LOG2 = 4;
  localparam int BOARD_X0  = 240;
  localparam int BOARD_Y0  = 80;
  localparam int BORDER    = 4;
  localparam int IDX_W     = 8;

  typedef logic [2:0] cell_t;
  localparam cell_t CELL_EMPTY = 3'd0;
  localparam cell_t CELL_I     = 3'd1;
  localparam cell_t CELL_O     = 3'd2;
  localparam cell_t CELL_T     = 3'd3;
  localparam cell_t CELL_S     = 3'd4;
  localparam cell_t CELL_Z     = 3'd5;
  localparam cell_t CELL_J     = 3'd6;
  localparam cell_t CELL_L     = 3'd7;

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_BORDER = 24'h808080;
  localparam logic [23:0] RGB_GRID   = 24'h202020;

  // Entry [0] is the empty cell and is never shown through the palette.
  localparam logic [7:0][23:0] PALETTE = {
    24'hFF8000, 24'h0000FF, 24'hFF0000, 24'h00FF00,
    24'hA000F0, 24'hFFFF00, 24'h00FFFF, 24'h000000
  };

  typedef enum logic {ST_IDLE, ST_COPY} copy_state_e;

  typedef struct packed {
    logic  de;
    logic  hs;
    logic  vs;
    logic  in_board;
    logic  in_border;
    logic  grid;
    cell_t code;
  } s1_t;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } s2_t;

  // Halves each channel separately to draw the darker cell edge.
  function automatic logic [23:0] edge_dim(input logic [23:0] rgb);
    return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
  endfunction

endpackage

// File: rtl/tetris_board_renderer_if.sv
// Game-logic side of the renderer: back-buffer write port, commit strobe and copy status.
interface tetris_board_renderer_if;
  logic                wr_en;
  logic [4:0]          wr_row;
  logic [3:0]          wr_col;
  tetris_pkg::cell_t   wr_color;
  logic                commit;
  logic                copy_busy;

  modport master (output wr_en, wr_row, wr_col, wr_color, commit, input copy_busy);
  modport slave  (input wr_en, wr_row, wr_col, wr_color, commit, output copy_busy);
endinterface

// File: rtl/tetris_board_mem.sv
// Back/front board buffers plus the copy FSM that moves back -> front on a vsync rising edge.
module tetris_board_mem
  import tetris_pkg::*;
(
  input  logic                   clk_fast,
  input  logic                   rst,
  input  logic                   vsync_in,
  tetris_board_renderer_if.slave wr_bus,
  input  logic [IDX_W-1:0]       rd_idx,
  output cell_t                  rd_code
);

  cell_t            back_q  [CELLS];
  cell_t            back_d  [CELLS];
  cell_t            front_q [CELLS];
  cell_t            front_d [CELLS];
  copy_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             vsync_prev_q;
  logic             vs_rise, start, copy_active, wr_ok;
  logic [IDX_W-1:0] wr_idx;

  assign wr_ok   = wr_bus.wr_en && (wr_bus.wr_row < 5'(ROWS)) && (wr_bus.wr_col < 4'(COLS));
  assign wr_idx  = 8'(wr_bus.wr_row) * 8'(COLS) + 8'(wr_bus.wr_col);
  assign vs_rise = vsync_in & ~vsync_prev_q;
  assign start   = (state_q == ST_IDLE) && pend_q && vs_rise;
  assign rd_code = front_q[rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      vsync_prev_q <= vsync_in;
    end
  end

  // NOTE: the buffers get a real reset so an aborted copy never leaves a partial frame; this keeps them in flops.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        back_q[i]  <= CELL_EMPTY;
        front_q[i] <= CELL_EMPTY;
      end
    end else begin
      back_q  <= back_d;
      front_q <= front_d;
    end
  end

  // NOTE: every comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COPY;
          idx_d   = '0;
        end
      end
      ST_COPY: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'(CELLS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    copy_active      = (state_q == ST_COPY);
    wr_bus.copy_busy = copy_active;
    // A commit in the same cycle as a start wins, so one more copy follows.
    pend_d           = wr_bus.commit | (pend_q & ~start);
  end

  always_comb begin
    back_d  = back_q;
    front_d = front_q;
    if (wr_ok) back_d[wr_idx] = wr_bus.wr_color;
    // A write hitting the cell being copied is forwarded straight into front.
    if (copy_active)
      front_d[idx_q] = (wr_ok && (wr_idx == idx_q)) ? wr_bus.wr_color : back_q[idx_q];
  end

endmodule

// File: rtl/tetris_board_renderer.sv
// Two-stage pixel pipeline: board lookup in S1, colour mux in S2; syncs ride along.
module tetris_board_renderer
  import tetris_pkg::*;
(
  input  logic                   clk_fast,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [10:0]            h_cnt,
  input  logic [9:0]             v_cnt,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  tetris_board_renderer_if.slave wr_bus,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int X_END = BOARD_X0 + (COLS << CELL_LOG2);
  localparam int Y_END = BOARD_Y0 + (ROWS << CELL_LOG2);

  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [7:0]       x;
  logic [8:0]       y;
  logic [3:0]       col;
  logic [4:0]       row;
  logic             in_board, in_frame, grid;
  logic [IDX_W-1:0] rd_idx;
  cell_t            rd_code;
  logic [23:0]      piece_rgb;

  tetris_board_mem u_mem (
    .clk_fast (clk_fast),
    .rst      (rst),
    .vsync_in (vsync_in),
    .wr_bus   (wr_bus),
    .rd_idx   (rd_idx),
    .rd_code  (rd_code)
  );

  always_comb begin
    x        = 8'(h_cnt - 11'(BOARD_X0));
    y        = 9'(v_cnt - 10'(BOARD_Y0));
    col      = 4'(x >> CELL_LOG2);
    row      = 5'(y >> CELL_LOG2);
    in_board = (h_cnt >= 11'(BOARD_X0)) && (h_cnt < 11'(X_END)) &&
               (v_cnt >= 10'(BOARD_Y0)) && (v_cnt < 10'(Y_END));
    in_frame = (h_cnt >= 11'(BOARD_X0 - BORDER)) && (h_cnt < 11'(X_END + BORDER)) &&
               (v_cnt >= 10'(BOARD_Y0 - BORDER)) && (v_cnt < 10'(Y_END + BORDER));
    grid     = (x[CELL_LOG2-1:0] == '1) | (y[CELL_LOG2-1:0] == '1);
    // Off-board pixels read cell 0 so the address never leaves the buffer.
    rd_idx   = in_board ? 8'(row) * 8'(COLS) + 8'(col) : '0;

    s1_d = s1_q;
    if (pix_en) begin
      s1_d.de        = de_in;
      s1_d.hs        = hsync_in;
      s1_d.vs        = vsync_in;
      s1_d.in_board  = in_board;
      s1_d.in_border = in_frame & ~in_board;
      s1_d.grid      = grid;
      s1_d.code      = rd_code;
    end
  end

  always_comb begin
    piece_rgb = PALETTE[s1_q.code];
    s2_d      = s2_q;
    if (pix_en) begin
      s2_d.de = s1_q.de;
      s2_d.hs = s1_q.hs;
      s2_d.vs = s1_q.vs;
      if (!s1_q.de)                       s2_d.rgb = RGB_BLACK;
      else if (s1_q.in_border)            s2_d.rgb = RGB_BORDER;
      else if (s1_q.in_board) begin
        if (s1_q.code == CELL_EMPTY)      s2_d.rgb = s1_q.grid ? RGB_GRID : RGB_BLACK;
        else                              s2_d.rgb = s1_q.grid ? edge_dim(piece_rgb) : piece_rgb;
      end else                            s2_d.rgb = RGB_BLACK;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign red       = s2_q.rgb[23:16];
  assign green     = s2_q.rgb[15:8];
  assign blue      = s2_q.rgb[7:0];
  assign de_out    = s2_q.de;
  assign hsync_out = s2_q.hs;
  assign vsync_out = s2_q.vs;

endmodule
